// File: rtl/nn_arith_pkg.sv
// Shared definitions for the NN arithmetic blocks: operand widths, divider
// latency and the sequential divider state encoding.
package nn_arith_pkg;

    localparam int NN_DIN0_W   = 36;
    localparam int NN_DIN1_W   = 10;
    localparam int NN_SDIV_LAT = NN_DIN0_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sdiv_state_e;

endpackage

// File: rtl/nn_sdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module nn_sdiv_step #(
    parameter int RW = 11
) (
    input  logic [RW-1:0] part_i,
    input  logic          bit_i,
    input  logic [RW-1:0] dvs_i,
    output logic [RW-1:0] rem_o,
    output logic          q_o
);

    logic [RW:0]   shifted;
    logic [RW-1:0] diff;

    assign shifted = {part_i, bit_i};
    assign q_o     = (shifted >= {1'b0, dvs_i});
    // When the subtraction is kept the result is below dvs_i, so RW bits hold it.
    assign diff    = shifted[RW-1:0] - dvs_i;
    assign rem_o   = q_o ? diff : shifted[RW-1:0];

endmodule

// File: rtl/nn_sdiv_36s_10s_seq.sv
// Iterative signed divider (36s / 10s), restoring radix-2, one quotient bit per
// cycle, C truncation semantics, valid/ready on both sides.
module nn_sdiv_36s_10s_seq
    import nn_arith_pkg::*;
#(
    parameter int din0_WIDTH = NN_DIN0_W,
    parameter int din1_WIDTH = NN_DIN1_W,
    parameter int ID         = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero,
    output sdiv_state_e           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid holds its data until taken.

    localparam int RW = din1_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH);

    sdiv_state_e           state_q;
    logic [CW-1:0]         cnt_q;
    logic [din0_WIDTH-1:0] dvd_q;
    logic [RW-1:0]         part_q;
    logic [RW-1:0]         dvs_q;
    logic                  qneg_q;
    logic                  rneg_q;
    logic [din0_WIDTH-1:0] quot_q;
    logic [din1_WIDTH-1:0] rem_q;
    logic                  dbz_q;
    logic                  out_valid_q;

    logic [din0_WIDTH-1:0] din0_mag_d;
    logic [RW-1:0]         din1_ext_d;
    logic [RW-1:0]         din1_mag_d;
    logic [din0_WIDTH-1:0] quot_fix_d;
    logic [din1_WIDTH-1:0] rem_fix_d;
    logic [RW-1:0]         step_rem;
    logic                  step_q;
    logic [31:0]           id_unused;

    assign id_unused  = ID;

    // Magnitude of -2^35 is 2^35, which still fits an unsigned dividend-width field.
    assign din0_mag_d = din0[din0_WIDTH-1] ? -din0 : din0;
    assign din1_ext_d = {din1[din1_WIDTH-1], din1};
    assign din1_mag_d = din1_ext_d[RW-1] ? -din1_ext_d : din1_ext_d;

    assign quot_fix_d = qneg_q ? -dvd_q : dvd_q;
    assign rem_fix_d  = rneg_q ? -part_q[din1_WIDTH-1:0] : part_q[din1_WIDTH-1:0];

    nn_sdiv_step #(
        .RW (RW)
    ) u_step (
        .part_i (part_q),
        .bit_i  (dvd_q[din0_WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            part_q      <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q  <= din0_mag_d;
                        dvs_q  <= din1_mag_d;
                        part_q <= '0;
                        cnt_q  <= CW'(din0_WIDTH - 1);
                        qneg_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                        rneg_q <= din0[din0_WIDTH-1];
                        if (din1 == '0) begin
                            quot_q  <= '1;
                            rem_q   <= '0;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                // Dividend bits leave at the top of dvd_q, quotient bits enter at the bottom.
                CALC: begin
                    dvd_q  <= {dvd_q[din0_WIDTH-2:0], step_q};
                    part_q <= step_rem;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= quot_fix_d;
                    rem_q   <= rem_fix_d;
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
